if_eval_sched: RTL and testbench

- Sequencer for the generated if-condition datapath (a > TH_A && b > TH_B).
- Walks a length-programmable window of paired array memories (array_a, array_b) and issues one read per element pair.
- Evaluates the condition on each returned pair and streams a per-element result flag.
- Accumulates a hit count and reports completion with a start/busy/done handshake.
- Sits between the top-level Python-generated control and the array RAMs.

---
 rtl/if_eval_sched_if.sv | 41 ++++
 rtl/if_eval_sched.sv | 166 ++++++++++++++++
 tb/tb_if_eval_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_eval_sched_if.sv
// Control, memory-read and result signals of the if_eval_sched sequencer.
// hit_idx is present only when IF_EVAL_FIRST_HIT_EN is defined.
interface if_eval_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] array_a_rdata;
  logic [DATA_W-1:0] array_b_rdata;
  logic              res_valid;
  logic [ADDR_W-1:0] res_idx;
  logic              if_condition;
  logic [ADDR_W:0]   hit_count;
  logic              busy;
  logic              done;
`ifdef IF_EVAL_FIRST_HIT_EN
  logic [ADDR_W-1:0] hit_idx;

  modport master (
    output start, len, abort, array_a_rdata, array_b_rdata,
    input  rd_en, rd_addr, res_valid, res_idx, if_condition, hit_count, busy, done, hit_idx
  );
  modport slave (
    input  start, len, abort, array_a_rdata, array_b_rdata,
    output rd_en, rd_addr, res_valid, res_idx, if_condition, hit_count, busy, done, hit_idx
  );
`else
  modport master (
    output start, len, abort, array_a_rdata, array_b_rdata,
    input  rd_en, rd_addr, res_valid, res_idx, if_condition, hit_count, busy, done
  );
  modport slave (
    input  start, len, abort, array_a_rdata, array_b_rdata,
    output rd_en, rd_addr, res_valid, res_idx, if_condition, hit_count, busy, done
  );
`endif
endinterface

// File: rtl/if_eval_sched.sv
// Sequencer for the (a > TH_A && b > TH_B) datapath: walks len elements of two RAMs,
// streams per-element flags and counts hits. IF_EVAL_FIRST_HIT_EN stops at the first hit.
module if_eval_sched #(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter int unsigned TH_A   = 65536,
  parameter int unsigned TH_B   = 458752
) (
  input  logic           clk,
  input  logic           reset,
  if_eval_sched_if.slave bus
);

  localparam int                LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  DEPTH_V = LEN_W'(DEPTH);
  localparam logic [DATA_W-1:0] TH_A_V  = DATA_W'(TH_A);
  localparam logic [DATA_W-1:0] TH_B_V  = DATA_W'(TH_B);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EVAL, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  len_eff_q, len_eff_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_idx_q, res_idx_d;
  logic              cond_q, cond_d;
  logic [LEN_W-1:0]  hit_count_q, hit_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] hit_idx_q, hit_idx_d;

  logic [LEN_W-1:0]  len_clamped;
  logic              cond;
  logic              last_elem;
  logic              abort_act;
  logic              stop_on_hit;

`ifdef IF_EVAL_FIRST_HIT_EN
  assign stop_on_hit = cond;
`else
  assign stop_on_hit = 1'b0;
`endif

  assign len_clamped = (bus.len > DEPTH_V) ? DEPTH_V : bus.len;
  assign cond        = (a_q > TH_A_V) && (b_q > TH_B_V);
  assign last_elem   = ({1'b0, idx_q} == (len_eff_q - LEN_W'(1)));
  assign abort_act   = bus.abort && (state_q inside {S_FETCH, S_WAIT, S_EVAL});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = (len_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_EVAL;
      S_EVAL:  state_d = (last_elem || stop_on_hit) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks every transition, including the final EVAL.
    if (abort_act) state_d = S_IDLE;
  end

  // NOTE: every signal gets a default at the top of the block so no path infers a latch.
  always_comb begin
    idx_d       = idx_q;
    len_eff_d   = len_eff_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_addr_d   = rd_addr_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    cond_d      = cond_q;
    hit_count_d = hit_count_q;
    hit_idx_d   = hit_idx_q;
    rd_en_d     = (state_d == S_FETCH);
    busy_d      = (state_d inside {S_FETCH, S_WAIT, S_EVAL});
    done_d      = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_eff_d   = len_clamped;
          hit_count_d = '0;
          hit_idx_d   = '0;
          idx_d       = '0;
        end
      end
      S_WAIT: begin
        a_d = bus.array_a_rdata;
        b_d = bus.array_b_rdata;
      end
      S_EVAL: begin
        if (!bus.abort) begin
          res_valid_d = 1'b1;
          res_idx_d   = idx_q;
          cond_d      = cond;
          if (cond) begin
            hit_count_d = hit_count_q + LEN_W'(1);
            if (hit_count_q == '0) hit_idx_d = idx_q;
          end
          if (!last_elem) idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase

    if (state_d == S_FETCH) rd_addr_d = idx_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      len_eff_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      cond_q      <= 1'b0;
      hit_count_q <= '0;
      hit_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      len_eff_q   <= len_eff_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      cond_q      <= cond_d;
      hit_count_q <= hit_count_d;
      hit_idx_q   <= hit_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the read-data capture registers carry no reset; they are always written in WAIT before EVAL reads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_idx      = res_idx_q;
  assign bus.if_condition = cond_q;
  assign bus.hit_count    = hit_count_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
`ifdef IF_EVAL_FIRST_HIT_EN
  assign bus.hit_idx      = hit_idx_q;
`endif

endmodule

// File: tb/tb_if_eval_sched.sv
// Directed self-checking bench for if_eval_sched with a synchronous-read RAM model.
// Covers the first-hit variant when IF_EVAL_FIRST_HIT_EN is defined.
module tb_if_eval_sched;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  int rd_log[$];
  int idx_log[$];
  int cond_log[$];

  if_eval_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  if_eval_sched #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TH_A(65536), .TH_B(458752)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM pair: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.array_a_rdata <= mem_a[bus.rd_addr];
      bus.array_b_rdata <= mem_b[bus.rd_addr];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_en) rd_log.push_back(int'(bus.rd_addr));
      if (bus.res_valid) begin
        idx_log.push_back(int'(bus.res_idx));
        cond_log.push_back(int'(bus.if_condition));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    idx_log.delete();
    cond_log.delete();
  endtask

  task automatic fill(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = a;
      mem_b[i] = b;
    end
  endtask

  // Starts a pass and returns the cycle count from start to the done pulse;
  // poke_at >= 0 re-pulses start (with a different len) at that cycle.
  task automatic run_pass(input logic [ADDR_W:0] l, input int poke_at, output int cyc);
    clear_logs();
    bus.len   = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      bus.start = (cyc == poke_at);
      if (cyc == poke_at) bus.len = 5'd2;
      tick();
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  int cyc;
  logic done_seen;
  int exp_cond [4] = '{1, 0, 0, 0};

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.len    = '0;
    bus.abort  = 1'b0;
    fill('0, '0);
    repeat (2) @(posedge clk);
    #3;
    check("rst_rd_en",     bus.rd_en,        0);
    check("rst_rd_addr",   bus.rd_addr,      0);
    check("rst_res_valid", bus.res_valid,    0);
    check("rst_res_idx",   bus.res_idx,      0);
    check("rst_cond",      bus.if_condition, 0);
    check("rst_hit_count", bus.hit_count,    0);
    check("rst_busy",      bus.busy,         0);
    check("rst_done",      bus.done,         0);
    reset = 1'b0;
    tick();

`ifndef IF_EVAL_FIRST_HIT_EN
    // Mixed pattern with both exact-threshold cases.
    mem_a[0] = 65537; mem_b[0] = 458753;
    mem_a[1] = 1;     mem_b[1] = 500000;
    mem_a[2] = 70000; mem_b[2] = 458752;
    mem_a[3] = 65536; mem_b[3] = 900000;
    run_pass(5'd4, -1, cyc);
    check("t1_done_latency", cyc, 14);
    check("t1_hit_count", bus.hit_count, 1);
    check("t1_busy_at_done", bus.busy, 0);
    check("t1_rd_count", rd_log.size(), 4);
    check("t1_res_count", cond_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_rd_addr_%0d", i), rd_log[i], i);
      check($sformatf("t1_res_idx_%0d", i), idx_log[i], i);
      check($sformatf("t1_cond_%0d", i), cond_log[i], exp_cond[i]);
    end
    tick();
    check("t1_done_one_cycle", bus.done, 0);
    check("t1_cond_held", bus.if_condition, 0);
    check("t1_hit_count_held", bus.hit_count, 1);
`endif

    // Zero-length pass.
    run_pass(5'd0, -1, cyc);
    check("t2_done_latency", cyc, 2);
    check("t2_hit_count", bus.hit_count, 0);
    check("t2_rd_count", rd_log.size(), 0);
    tick();

`ifndef IF_EVAL_FIRST_HIT_EN
    // Clamped length, all hits, with a start pulse while busy.
    fill(32'd100000, 32'd500000);
    run_pass(5'd20, 10, cyc);
    check("t3_done_latency", cyc, 50);
    check("t3_hit_count", bus.hit_count, 16);
    check("t3_res_count", idx_log.size(), 16);
    check("t3_rd_count", rd_log.size(), 16);
    check("t3_last_res_idx", idx_log[15], 15);
    check("t3_last_rd_addr", rd_log[15], 15);
    tick();

    // Abort during WAIT of element 2 of an 8-element all-hit pass.
    clear_logs();
    bus.len   = 5'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    check("t5_busy_before_abort", bus.busy, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_busy_after_abort", bus.busy, 0);
    check("t5_hit_count", bus.hit_count, 2);
    check("t5_done", bus.done, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_seen = done_seen | bus.done;
    end
    check("t5_no_done_pulse", done_seen, 0);
    check("t5_res_count", cond_log.size(), 2);
    check("t5_rd_count", rd_log.size(), 3);
    check("t5_hit_count_held", bus.hit_count, 2);

    // Asynchronous reset in the middle of EVAL of element 1.
    bus.len   = 5'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("t6_hit_count_pre", bus.hit_count, 1);
    check("t6_busy_pre", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rd_en",     bus.rd_en,        0);
    check("t6_rd_addr",   bus.rd_addr,      0);
    check("t6_res_valid", bus.res_valid,    0);
    check("t6_res_idx",   bus.res_idx,      0);
    check("t6_cond",      bus.if_condition, 0);
    check("t6_hit_count", bus.hit_count,    0);
    check("t6_busy",      bus.busy,         0);
    check("t6_done",      bus.done,         0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
`endif

    // Single hit at index 3.
    fill(32'd1, 32'd500000);
    mem_a[3] = 100000;
    run_pass(5'd6, -1, cyc);
    check("t7_hit_count", bus.hit_count, 1);
`ifdef IF_EVAL_FIRST_HIT_EN
    check("t7_done_latency", cyc, 14);
    check("t7_hit_idx", bus.hit_idx, 3);
    check("t7_res_count", cond_log.size(), 4);
`else
    check("t7_done_latency", cyc, 20);
    check("t7_res_count", cond_log.size(), 6);
    check("t7_cond_2", cond_log[2], 0);
    check("t7_cond_3", cond_log[3], 1);
    check("t7_cond_5", cond_log[5], 0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
